// File: rtl/breath_pkg.sv
// breath_pkg: shared constants for the breathing-LED duty generator
// and for the two-counter PWM block it feeds.
package breath_pkg;

    localparam int BOUND_W = 8;

    localparam int PERIOD_DEF       = 200;
    localparam int DUTY_MIN_DEF     = 2;
    localparam int DUTY_MAX_DEF     = 198;
    localparam int STEP_DEF         = 4;
    localparam int HOLD_PERIODS_DEF = 8;

    typedef enum logic [1:0] {
        PH_RAMP_UP   = 2'd0,
        PH_HOLD_TOP  = 2'd1,
        PH_RAMP_DOWN = 2'd2,
        PH_HOLD_BOT  = 2'd3
    } phase_t;

endpackage

// File: rtl/breath_period_tick.sv
// breath_period_tick: finds the end of each PWM period as the
// 1->0 edge of the PWM block's state output.
module breath_period_tick (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm_state,
    output logic tick
);

    logic pwm_prev;

    // Track the previous PWM state every cycle, regardless of enable.
    always_ff @(posedge i_clk) begin
        if (!i_rst) pwm_prev <= 1'b0;
        else        pwm_prev <= i_pwm_state;
    end

    assign tick = pwm_prev & ~i_pwm_state;

endmodule

// File: rtl/breath_duty_gen.sv
// breath_duty_gen: ramps, holds and releases the PWM on-bound once per
// completed PWM period, keeping the two bounds summing to PERIOD.
module breath_duty_gen
    import breath_pkg::*;
#(
    parameter int PERIOD       = PERIOD_DEF,
    parameter int DUTY_MIN     = DUTY_MIN_DEF,
    parameter int DUTY_MAX     = DUTY_MAX_DEF,
    parameter int STEP         = STEP_DEF,
    parameter int HOLD_PERIODS = HOLD_PERIODS_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_pwm_state,
    output logic [BOUND_W-1:0] o_upperBound1,
    output logic [BOUND_W-1:0] o_upperBound2,
    output logic [1:0]         o_phase,
    output logic               o_cycle_done
);

    localparam logic [8:0] MAX9  = 9'(DUTY_MAX);
    localparam logic [8:0] MIN9  = 9'(DUTY_MIN);
    localparam logic [8:0] STEP9 = 9'(STEP);

    localparam logic [BOUND_W-1:0] PER8  = BOUND_W'(PERIOD);
    localparam logic [BOUND_W-1:0] MAX8  = BOUND_W'(DUTY_MAX);
    localparam logic [BOUND_W-1:0] MIN8  = BOUND_W'(DUTY_MIN);
    localparam logic [BOUND_W-1:0] STEP8 = BOUND_W'(STEP);
    localparam logic [BOUND_W-1:0] HOLD_LAST = BOUND_W'(HOLD_PERIODS - 1);

    logic               tick;
    phase_t             phase;
    phase_t             phase_nxt;
    logic [BOUND_W-1:0] duty;
    logic [BOUND_W-1:0] duty_nxt;
    logic [BOUND_W-1:0] hold_cnt;
    logic [BOUND_W-1:0] hold_nxt;
    logic               done_nxt;
    logic [8:0]         sum_up;
    logic [8:0]         lim_dn;

    breath_period_tick u_tick (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pwm_state (i_pwm_state),
        .tick        (tick)
    );

    // State, duty and both bounds are registered together so a PWM
    // period never sees a half-updated pair of bounds.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            phase         <= PH_RAMP_UP;
            duty          <= MIN8;
            hold_cnt      <= '0;
            o_upperBound1 <= PER8 - MIN8;
            o_upperBound2 <= MIN8;
            o_cycle_done  <= 1'b0;
        end else begin
            phase         <= phase_nxt;
            duty          <= duty_nxt;
            hold_cnt      <= hold_nxt;
            o_upperBound1 <= PER8 - duty_nxt;
            o_upperBound2 <= duty_nxt;
            o_cycle_done  <= done_nxt;
        end
    end

    // Next phase/duty/hold count; only an enabled period end advances.
    always_comb begin
        phase_nxt = phase;
        duty_nxt  = duty;
        hold_nxt  = hold_cnt;
        done_nxt  = 1'b0;
        sum_up    = {1'b0, duty} + STEP9;
        lim_dn    = MIN9 + STEP9;
        if (tick && i_en) begin
            unique case (phase)
                PH_RAMP_UP: begin
                    if (sum_up >= MAX9) begin
                        duty_nxt  = MAX8;
                        hold_nxt  = '0;
                        phase_nxt = PH_HOLD_TOP;
                    end else begin
                        duty_nxt = sum_up[BOUND_W-1:0];
                    end
                end
                PH_HOLD_TOP: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt  = '0;
                        phase_nxt = PH_RAMP_DOWN;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                PH_RAMP_DOWN: begin
                    if ({1'b0, duty} <= lim_dn) begin
                        duty_nxt  = MIN8;
                        hold_nxt  = '0;
                        phase_nxt = PH_HOLD_BOT;
                    end else begin
                        duty_nxt = duty - STEP8;
                    end
                end
                PH_HOLD_BOT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt  = '0;
                        phase_nxt = PH_RAMP_UP;
                        done_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_phase = phase;

endmodule

// File: tb/tb_breath_duty_gen.sv
// tb_breath_duty_gen: random PWM periods and enables against a
// per-period breath-sequence model, plus directed literal checks.
module tb_breath_duty_gen;

    localparam int PERIOD = 20;
    localparam int DMIN   = 1;
    localparam int DMAX   = 18;
    localparam int STEP   = 3;
    localparam int HOLD   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic       pwm = 1'b0;
    logic [7:0] ub1;
    logic [7:0] ub2;
    logic [1:0] ph;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    int seq_d[$];
    int seq_p[$];
    int pos      = 0;
    bit prev     = 1'b0;
    bit exp_done = 1'b0;
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    breath_duty_gen #(
        .PERIOD       (PERIOD),
        .DUTY_MIN     (DMIN),
        .DUTY_MAX     (DMAX),
        .STEP         (STEP),
        .HOLD_PERIODS (HOLD)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_pwm_state   (pwm),
        .o_upperBound1 (ub1),
        .o_upperBound2 (ub2),
        .o_phase       (ph),
        .o_cycle_done  (done)
    );

    // Model: position within the precomputed per-period breath sequence.
    always @(posedge clk) begin
        if (!rst) begin
            pos      = 0;
            prev     = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (prev && !pwm && en) begin
                if (pos == seq_d.size() - 1) begin
                    pos      = 0;
                    exp_done = 1'b1;
                end else begin
                    pos++;
                end
            end
            prev = pwm;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_on) begin
            n_cmp++;
            if (ub2 !== 8'(seq_d[pos]) || ub1 !== 8'(PERIOD - seq_d[pos]) ||
                ph !== 2'(seq_p[pos]) || done !== exp_done) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t got ub1=%0d ub2=%0d ph=%0d done=%0d exp ub1=%0d ub2=%0d ph=%0d done=%0d",
                         $time, ub1, ub2, ph, done,
                         PERIOD - seq_d[pos], seq_d[pos], seq_p[pos], exp_done);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic period(input int hi, input int lo);
        pwm = 1'b1;
        cyc(hi);
        pwm = 1'b0;
        cyc(lo);
    endtask

    task automatic rperiod();
        period($urandom_range(1, 4), $urandom_range(1, 4));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    initial begin
        int d;
        d = DMIN;
        do begin
            seq_d.push_back(d);
            seq_p.push_back(0);
            d = d + STEP;
        end while (d < DMAX);
        repeat (HOLD) begin
            seq_d.push_back(DMAX);
            seq_p.push_back(1);
        end
        d = DMAX;
        do begin
            seq_d.push_back(d);
            seq_p.push_back(2);
            d = d - STEP;
        end while (d > DMIN);
        repeat (HOLD) begin
            seq_d.push_back(DMIN);
            seq_p.push_back(3);
        end

        chk("model_len", seq_d.size(), 16);
        chk("model_top", seq_d[6], 18);
        chk("model_dn_phase", seq_p[8], 2);
        chk("model_last_dn", seq_d[13], 3);

        @(negedge clk);
        rst = 1'b0;
        pwm = 1'b0;
        cyc(2);
        rst = 1'b1;
        check_on = 1'b1;

        chk("rst_ub2", ub2, 1);
        chk("rst_ub1", ub1, 19);
        chk("rst_phase", ph, 0);
        chk("rst_done", done, 0);

        pwm = 1'b1;
        cyc(5);
        chk("rise_no_update", ub2, 1);
        pwm = 1'b0;
        cyc(2);
        chk("first_tick", ub2, 4);

        repeat (4) rperiod();
        chk("ramp_16", ub2, 16);
        chk("ramp_16_phase", ph, 0);
        rperiod();
        chk("ramp_sat", ub2, 18);
        chk("ramp_sat_ub1", ub1, 2);
        chk("top_phase", ph, 1);

        repeat (2) rperiod();
        chk("down_phase", ph, 2);
        chk("down_hold_duty", ub2, 18);
        repeat (6) rperiod();
        chk("down_sat", ub2, 1);
        chk("bot_phase", ph, 3);
        rperiod();
        pwm = 1'b1;
        cyc(2);
        pwm = 1'b0;
        cyc(1);
        chk("wrap_done", done, 1);
        chk("wrap_phase", ph, 0);
        cyc(1);
        chk("done_one_cycle", done, 0);

        repeat (3) rperiod();
        chk("pre_freeze", ub2, 10);
        en = 1'b0;
        repeat (3) rperiod();
        chk("frozen", ub2, 10);
        en = 1'b1;
        rperiod();
        chk("no_catchup", ub2, 13);

        repeat (2) rperiod();
        chk("hold_top_again", ph, 1);
        do_reset();
        chk("midrst_ub2", ub2, 1);
        chk("midrst_ub1", ub1, 19);
        chk("midrst_phase", ph, 0);
        rperiod();
        chk("after_rst_tick", ub2, 4);

        pwm = 1'b1;
        cyc(100);
        chk("stuck_high", ub2, 4);
        pwm = 1'b0;
        cyc(100);
        chk("stuck_low_one", ub2, 7);

        repeat (80) begin
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 24) == 0) do_reset();
            rperiod();
        end
        en = 1'b1;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/breath_duty_gen.md
Name: breath_duty_gen

Overview:
Upstream stage of the two-counter PWM block in the breathing-LED design. Drives that block's upper-bound inputs so the LED duty ramps up, holds, ramps down and holds again, repeating forever. Watches the PWM block's state output to find PWM period boundaries. Changes duty exactly once per completed PWM period, so each period runs with consistent bounds.

Parameters:
PERIOD, 200, constant sum of the two bounds; the range is 2..255.
DUTY_MIN, 2, lowest on-bound (upperBound2) value; must be less than DUTY_MAX.
DUTY_MAX, 198, highest on-bound value; must be at most PERIOD.
STEP, 4, duty increment or decrement applied per PWM period while ramping; the range is 1..255.
HOLD_PERIODS, 8, number of PWM periods spent in each hold phase; the range is 1..255.

Ports:
i_clk  input  1  single system clock, rising edge.
i_rst  input  1  synchronous reset, active-low.
i_en  input  1  when low, duty and phase are frozen; edge tracking continues.
i_pwm_state  input  1  state output of the downstream two-counter PWM block.
o_upperBound1  output  8  off-phase bound; always equals PERIOD - duty.
o_upperBound2  output  8  on-phase bound; always equals duty.
o_phase  output  2  current phase: 0=RAMP_UP, 1=HOLD_TOP, 2=RAMP_DOWN, 3=HOLD_BOT.
o_cycle_done  output  1  one-cycle pulse issued when the final HOLD_BOT period completes (breath cycle wrap).

Behaviour:
- Reset is sampled on the rising edge of i_clk while i_rst is 0. It sets:
  - duty = DUTY_MIN
  - phase = RAMP_UP
  - hold_cnt = 0
  - pwm_prev = 0
  - o_upperBound1 = PERIOD - DUTY_MIN
  - o_upperBound2 = DUTY_MIN
  - o_cycle_done = 0
- Reset asserted mid-ramp or mid-hold returns all state to these values on the same edge. No partial update is kept.
- pwm_prev registers i_pwm_state every cycle, including when i_en is 0.
- tick = pwm_prev & ~i_pwm_state, i.e. the 1->0 falling edge of the PWM state, which marks the end of one PWM period.
- Updates happen only on a cycle where tick=1 and i_en=1. Duty, phase, hold_cnt and both bounds update on that same clock edge. Latency is 0 cycles after the falling edge is sampled.
- When tick=1 and i_en=0, nothing changes and the tick is lost; it is not queued.
- Arithmetic uses 9-bit intermediates; the bounds never wrap.
- RAMP_UP: if duty + STEP >= DUTY_MAX, set duty = DUTY_MAX (saturating), clear hold_cnt and go to HOLD_TOP. Otherwise duty += STEP.
- HOLD_TOP: if hold_cnt == HOLD_PERIODS - 1, clear hold_cnt and go to RAMP_DOWN. Otherwise hold_cnt++. Duty is unchanged.
- RAMP_DOWN: if duty <= DUTY_MIN + STEP, set duty = DUTY_MIN (saturating), clear hold_cnt and go to HOLD_BOT. Otherwise duty -= STEP.
- HOLD_BOT: same counting as HOLD_TOP. On exit it goes to RAMP_UP and pulses o_cycle_done high for exactly that one cycle.
- o_upperBound1 + o_upperBound2 == PERIOD holds every cycle after reset.
- Both bounds are registered outputs with no combinational path from any input.
- If i_pwm_state is stuck at either level, no ticks occur and the outputs stay constant.
- A tick cannot occur on consecutive cycles, because the edge requires pwm_prev = 1.
- Unused phase encodings do not exist: 2 bits cover exactly 4 states.

Decomposition:
- Shared package breath_pkg holds:
  - phase constants PH_RAMP_UP, PH_HOLD_TOP, PH_RAMP_DOWN, PH_HOLD_BOT (2-bit);
  - BOUND_W = 8;
  - the default values of PERIOD, DUTY_MIN, DUTY_MAX and STEP, for reuse by the PWM block's bench.
- One sub-module: breath_period_tick. It contains the pwm_prev register and falling-edge detect, takes i_clk/i_rst, and outputs tick.
- The FSM, the duty datapath and the hold counter stay in breath_duty_gen.

Test Plan:
All scenarios use PERIOD=20, DUTY_MIN=1, DUTY_MAX=18, STEP=3, HOLD_PERIODS=2, and a bench model of the PWM block that toggles i_pwm_state.
1. Reset -> o_upperBound2=1, o_upperBound1=19, o_phase=0 and o_cycle_done=0, held until the first falling edge.
2. Ramp up -> o_upperBound2 steps 1,4,7,10,13,16, then 18 (saturated), with one change per falling edge and phase becoming 1 on the 18 update. Bound1 always equals 20 - bound2.
3. Hold and ramp down -> 2 ticks at 18, then phase=2. Values go 15,12,9,6,3, then 1 (saturated), then phase=3. After 2 more ticks phase=0 and o_cycle_done is high for exactly one cycle.
4. i_en=0 across 3 falling edges mid-ramp at duty 10 -> no output change. After re-enable, the next edge gives 13; no catch-up.
5. i_rst=0 for one cycle during HOLD_TOP -> on the next edge the outputs are 1/19 and phase=0, and the following tick gives 4.
6. i_pwm_state held high for 100 cycles, then held low for 100 cycles -> exactly one update, at the 1->0 transition. A rising edge alone causes no update.
